// File: rtl/video_sobel_edge_if.sv
// Pixel stream bundle for the Sobel edge stage.
// Source side drives I_*, the filter drives O_*.
interface video_sobel_edge_if;
  logic       I_en;
  logic       I_de;
  logic       I_hs;
  logic       I_vs;
  logic [7:0] I_data_r;
  logic [7:0] I_data_g;
  logic [7:0] I_data_b;
  logic       O_de;
  logic       O_hs;
  logic       O_vs;
  logic [7:0] O_data_r;
  logic [7:0] O_data_g;
  logic [7:0] O_data_b;

  modport master (
    output I_en, I_de, I_hs, I_vs,
    output I_data_r, I_data_g, I_data_b,
    input  O_de, O_hs, O_vs,
    input  O_data_r, O_data_g, O_data_b
  );

  modport slave (
    input  I_en, I_de, I_hs, I_vs,
    input  I_data_r, I_data_g, I_data_b,
    output O_de, O_hs, O_vs,
    output O_data_r, O_data_g, O_data_b
  );
endinterface

// File: rtl/video_sobel_edge.sv
// Streaming 3x3 Sobel edge detector, luma in, grey RGB out.
// Sync/DE/bypass data follow a fixed 4-clock delay chain.
module video_sobel_edge #(
  parameter int H_RES  = 1280,
  parameter int LAT    = 4,
  parameter bit VS_POL = 1'b1
) (
  input  logic              I_pxl_clk,
  input  logic              I_rst_n,
  video_sobel_edge_if.slave vif
);
  localparam int XW = $clog2(H_RES);
  localparam logic [XW-1:0] XMAX = XW'(H_RES - 1);

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       en;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } tap_t;

  tap_t tap_in;
  tap_t tap_o;
  tap_t dly_q [LAT-1];

  logic [XW-1:0] x_q, x_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    y_q, y_d;

  logic [15:0] lum_sum;
  logic [7:0]  lum;
  logic [7:0]  lb0_q [H_RES];
  logic [7:0]  lb1_q [H_RES];
  logic [7:0]  lb0_rd, lb1_rd;
  logic        wr_en;

  logic [2:0][2:0][7:0] win_q, win_d;
  logic                 bord1_q, bord1_d;
  logic                 bord2_q;

  logic [9:0]         sx_p, sx_n, sy_p, sy_n;
  logic signed [10:0] gx_q, gx_d, gy_q, gy_d;
  logic [10:0]        ax, ay;
  logic [11:0]        mag;
  logic [7:0]         mag_q, mag_d;

  logic       o_de_q, o_hs_q, o_vs_q;
  logic [7:0] o_r_q, o_g_q, o_b_q;
  logic [7:0] o_r_d, o_g_d, o_b_d;

  always_comb begin
    tap_in.de = vif.I_de;
    tap_in.hs = vif.I_hs;
    tap_in.vs = vif.I_vs;
    tap_in.en = vif.I_en;
    tap_in.r  = vif.I_data_r;
    tap_in.g  = vif.I_data_g;
    tap_in.b  = vif.I_data_b;
  end

  always_comb begin
    lum_sum = 16'd77  * {8'd0, vif.I_data_r}
            + 16'd150 * {8'd0, vif.I_data_g}
            + 16'd29  * {8'd0, vif.I_data_b};
    lum = 8'(lum_sum >> 8);
  end

  // x saturates; ovf marks pixels past the last RAM column
  always_comb begin
    x_d   = x_q;
    ovf_d = ovf_q;
    y_d   = y_q;
    if (vif.I_de) begin
      if (x_q == XMAX) ovf_d = 1'b1;
      else             x_d   = x_q + 1'b1;
    end else begin
      x_d   = '0;
      ovf_d = 1'b0;
    end
    if (dly_q[0].de && !vif.I_de && y_q != 2'd2)
      y_d = y_q + 2'd1;
    if (vif.I_vs == VS_POL)
      y_d = '0;
  end

  assign lb0_rd = lb0_q[x_q];
  assign lb1_rd = lb1_q[x_q];
  assign wr_en  = vif.I_de && !ovf_q;

  always_ff @(posedge I_pxl_clk) begin
    if (wr_en) begin
      lb0_q[x_q] <= lum;
      lb1_q[x_q] <= lb0_rd;
    end
  end

  always_comb begin
    win_d = win_q;
    if (vif.I_de) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = lum;
    end
    bord1_d = (x_q < XW'(2)) || (y_q < 2'd2);
  end

  always_comb begin
    sx_p = {2'b0, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0}
         + {2'b0, win_q[2][2]};
    sx_n = {2'b0, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0}
         + {2'b0, win_q[2][0]};
    sy_p = {2'b0, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0}
         + {2'b0, win_q[2][2]};
    sy_n = {2'b0, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0}
         + {2'b0, win_q[0][2]};
    gx_d = $signed({1'b0, sx_p}) - $signed({1'b0, sx_n});
    gy_d = $signed({1'b0, sy_p}) - $signed({1'b0, sy_n});
  end

  always_comb begin
    ax    = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
    ay    = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
    mag   = {1'b0, ax} + {1'b0, ay};
    mag_d = '0;
    if (!bord2_q)
      mag_d = (mag > 12'd255) ? 8'hff : mag[7:0];
  end

  always_comb begin
    tap_o = dly_q[LAT-2];
    o_r_d = '0;
    o_g_d = '0;
    o_b_d = '0;
    if (tap_o.de) begin
      if (tap_o.en) begin
        o_r_d = mag_q;
        o_g_d = mag_q;
        o_b_d = mag_q;
      end else begin
        o_r_d = tap_o.r;
        o_g_d = tap_o.g;
        o_b_d = tap_o.b;
      end
    end
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < LAT-1; i++) dly_q[i] <= '0;
      x_q     <= '0;
      ovf_q   <= 1'b0;
      y_q     <= '0;
      win_q   <= '0;
      bord1_q <= 1'b1;
      bord2_q <= 1'b1;
      gx_q    <= '0;
      gy_q    <= '0;
      mag_q   <= '0;
      o_de_q  <= 1'b0;
      o_hs_q  <= 1'b0;
      o_vs_q  <= 1'b0;
      o_r_q   <= '0;
      o_g_q   <= '0;
      o_b_q   <= '0;
    end else begin
      dly_q[0] <= tap_in;
      for (int i = 1; i < LAT-1; i++) dly_q[i] <= dly_q[i-1];
      x_q     <= x_d;
      ovf_q   <= ovf_d;
      y_q     <= y_d;
      win_q   <= win_d;
      bord1_q <= bord1_d;
      bord2_q <= bord1_q;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      mag_q   <= mag_d;
      o_de_q  <= tap_o.de;
      o_hs_q  <= tap_o.hs;
      o_vs_q  <= tap_o.vs;
      o_r_q   <= o_r_d;
      o_g_q   <= o_g_d;
      o_b_q   <= o_b_d;
    end
  end

  assign vif.O_de     = o_de_q;
  assign vif.O_hs     = o_hs_q;
  assign vif.O_vs     = o_vs_q;
  assign vif.O_data_r = o_r_q;
  assign vif.O_data_g = o_g_q;
  assign vif.O_data_b = o_b_q;
endmodule

// File: tb/tb_video_sobel_edge.sv
// Bench for video_sobel_edge: small frames, frame-level luma
// model, per-pixel scoreboard with 4-clock latency.
module tb_video_sobel_edge;
  localparam int H_RES = 1280;
  localparam int HB    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_sobel_edge_if vif ();

  video_sobel_edge #(
    .H_RES (H_RES),
    .LAT   (4),
    .VS_POL(1'b1)
  ) dut (
    .I_pxl_clk(clk),
    .I_rst_n  (rst_n),
    .vif      (vif)
  );

  typedef struct {
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    bit         cs;
    bit         cd;
  } exp_t;

  typedef struct {
    string      name;
    int         pat;
    int         w;
    int         h;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       en0;
    int         tog;
    logic [7:0] hv;
    int         hits;
  } vec_t;

  exp_t       sbq[$];
  int         checks   = 0;
  int         failures = 0;
  int         hits     = 0;
  logic [7:0] hv       = 8'd0;
  bit         corrupt  = 1'b0;
  logic [7:0] lm [8][1300];

  function automatic int luma(input int r, input int g, input int b);
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  function automatic int gradmag(input int row, input int col);
    int p[3][3];
    int gx, gy, m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = int'(lm[row-2+i][col-2+j]);
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  function automatic logic hsf(input int c, input int w);
    return (c >= w + 2) && (c < w + 6);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic rs, input logic de, input logic hs,
                     input logic vs, input logic en,
                     input logic [7:0] r, input logic [7:0] g,
                     input logic [7:0] b, input logic [7:0] ev,
                     input bit cd);
    exp_t e;
    exp_t o;
    @(posedge clk);
    #1;
    rst_n        = rs;
    vif.I_de     = de;
    vif.I_hs     = hs;
    vif.I_vs     = vs;
    vif.I_en     = en;
    vif.I_data_r = r;
    vif.I_data_g = g;
    vif.I_data_b = b;
    e.de = de;
    e.hs = hs;
    e.vs = vs;
    e.cs = rs;
    e.cd = cd && rs;
    if (!de) begin
      e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
    end else if (en) begin
      e.r = ev; e.g = ev; e.b = ev;
    end else begin
      e.r = r; e.g = g; e.b = b;
    end
    sbq.push_back(e);
    @(negedge clk);
    if (!rst_n)
      check("reset_out",
            int'({vif.O_de, vif.O_hs, vif.O_vs,
                  vif.O_data_r, vif.O_data_g, vif.O_data_b}), 0);
    if (sbq.size() > 4) begin
      o = sbq.pop_front();
      if (rst_n && o.cs)
        check("sync", int'({vif.O_de, vif.O_hs, vif.O_vs}),
              int'({o.de, o.hs, o.vs}));
      if (rst_n && o.cd) begin
        check("data", int'({vif.O_data_r, vif.O_data_g, vif.O_data_b}),
              int'({o.r, o.g, o.b}));
        if (o.de && vif.O_data_r == hv) hits++;
      end
    end
  endtask

  task automatic frame(input int pat, input int w, input int h,
                       input logic [7:0] cr, input logic [7:0] cg,
                       input logic [7:0] cb, input logic en0,
                       input int tog, input int rr, input int rc);
    int         tot;
    int         ev;
    bit         on;
    logic       en;
    logic       rs;
    logic [7:0] pr, pg, pb;
    tot     = w + HB;
    corrupt = 1'b0;
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < tot; c++)
        cyc(1'b1, 1'b0, hsf(c, w), 1'b1, en0,
            8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
    for (int row = 0; row < h; row++) begin
      for (int c = 0; c < tot; c++) begin
        if (c < w) begin
          on = (pat == 0) || (pat == 1 && c >= w / 2) ||
               (pat == 2 && row >= h / 2);
          pr = on ? cr : 8'd0;
          pg = on ? cg : 8'd0;
          pb = on ? cb : 8'd0;
          lm[row][c] = 8'(luma(int'(pr), int'(pg), int'(pb)));
          en = (c < tog) ? en0 : !en0;
          rs = !(row == rr && c >= rc && c < rc + 10);
          if (!rs) corrupt = 1'b1;
          ev = (row < 2 || c < 2 || c >= H_RES) ? 0 : gradmag(row, c);
          cyc(rs, 1'b1, 1'b0, 1'b0, en, pr, pg, pb, 8'(ev),
              !corrupt && c < H_RES);
        end else begin
          cyc(1'b1, 1'b0, hsf(c, w), 1'b0, en0,
              8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        end
      end
    end
    for (int c = 0; c < tot; c++)
      cyc(1'b1, 1'b0, hsf(c, w), 1'b0, en0,
          8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    tbl[0] = '{"flat",        0, 24,   8, 100, 100, 100, 1'b1, 999,  0,   192};
    tbl[1] = '{"vstep",       1, 24,   8, 255, 255, 255, 1'b1, 999,  255, 12};
    tbl[2] = '{"hstep",       2, 24,   8, 255, 255, 255, 1'b1, 999,  255, 44};
    tbl[3] = '{"bypass",      1, 24,   8, 255, 255, 255, 1'b0, 999,  255, 96};
    tbl[4] = '{"en_toggle",   1, 128,  6, 255, 255, 255, 1'b1, 100,  255, 176};
    tbl[5] = '{"luma_r40",    2, 24,   8, 40,  0,   0,   1'b1, 999,  48,  44};
    tbl[6] = '{"luma_b200",   2, 24,   8, 0,   0,   200, 1'b1, 999,  88,  44};
    tbl[7] = '{"luma_g30",    2, 24,   8, 0,   30,  0,   1'b1, 999,  68,  44};
    tbl[8] = '{"luma_grey10", 2, 24,   8, 10,  10,  10,  1'b1, 999,  40,  44};
    tbl[9] = '{"long_line",   1, 1300, 4, 255, 255, 255, 1'b1, 9999, 255, 4};

    vif.I_de = 1'b0; vif.I_hs = 1'b0; vif.I_vs = 1'b0; vif.I_en = 1'b0;
    vif.I_data_r = 8'd0; vif.I_data_g = 8'd0; vif.I_data_b = 8'd0;

    repeat (5)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          8'd0, 8'd0, 8'd0, 8'd0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      hv   = tbl[i].hv;
      hits = 0;
      frame(tbl[i].pat, tbl[i].w, tbl[i].h, tbl[i].r, tbl[i].g,
            tbl[i].b, tbl[i].en0, tbl[i].tog, -1, 0);
      check({"hits_", tbl[i].name}, hits, tbl[i].hits);
    end

    hv   = 8'd255;
    hits = 0;
    frame(1, 24, 8, 8'd255, 8'd255, 8'd255, 1'b1, 999, 3, 5);
    check("hits_rst_frame", hits, 2);
    hits = 0;
    frame(1, 24, 8, 8'd255, 8'd255, 8'd255, 1'b1, 999, -1, 0);
    check("hits_after_rst", hits, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
